// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter
// Gives one internal requester at a time the 8-bit bidirectional uio pad bus.
// Requesters are served round-robin and each grant is limited to MAX_HOLD
// cycles. When the bus direction changes, the arbiter keeps the pads
// released (uio_oe=0) for TURN_CYC dead cycles before it issues the grant.
//
// Timing of a grant, one OWN cycle at a time:
//   - gnt is registered, so it is high during exactly the OWN cycles.
//   - A writer's data is sampled in each OWN cycle and shows on uio_out in
//     the next cycle. uio_oe goes high together with that data.
//   - uio_oe drops on the same edge that ends the grant, so the pads are
//     never driven in IDLE.
//   - A reader's uio_in is captured into rdata in each OWN cycle, and rvalid
//     is high in the cycle after each capture.
module uio_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   dir,
  input  logic [8*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         rdata,
  output logic               rvalid,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe
);

  localparam int IDX_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int TURN_W = (TURN_CYC > 2) ? $clog2(TURN_CYC) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]    N_REQ_EXT = (IDX_W + 1)'(N_REQ);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);
  localparam logic [7:0]        HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    OWN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              owner_dir_q, owner_dir_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              last_dir_q, last_dir_d;
  logic [7:0]        hold_q, hold_d;
  logic [TURN_W-1:0] turn_q, turn_d;

  logic [N_REQ-1:0]  gnt_d;
  logic [7:0]        oe_d;
  logic [7:0]        out_d;
  logic [7:0]        rdata_d;
  logic              rvalid_d;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [7:0]        wbyte [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_wbyte
      assign wbyte[gi] = wdata[8*gi +: 8];
    end
  endgenerate

  // Round-robin pick: the first active request found at or after rr_ptr,
  // wrapping past the last requester.
  always_comb begin
    logic [IDX_W:0]   cand_ext;
    logic [IDX_W-1:0] cand;
    cand_ext  = '0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_ext = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (cand_ext >= N_REQ_EXT) begin
        cand_ext = cand_ext - N_REQ_EXT;
      end
      cand = cand_ext[IDX_W-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic and next values of the registered pad and grant outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    owner_dir_d = owner_dir_q;
    rr_ptr_d    = rr_ptr_q;
    last_dir_d  = last_dir_q;
    hold_d      = hold_q;
    turn_d      = turn_q;
    gnt_d       = '0;
    oe_d        = 8'h00;
    out_d       = uio_out;
    rdata_d     = rdata;
    rvalid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ena && win_found) begin
          owner_d     = win_idx;
          owner_dir_d = dir[win_idx];
          hold_d      = '0;
          if (dir[win_idx] == last_dir_q) begin
            state_d        = OWN;
            gnt_d[win_idx] = 1'b1;
          end else begin
            state_d = TURN;
            turn_d  = '0;
          end
        end
      end

      TURN: begin
        if (!ena) begin
          state_d = IDLE;
          turn_d  = '0;
        end else if (turn_q == TURN_LAST) begin
          state_d        = OWN;
          turn_d         = '0;
          last_dir_d     = owner_dir_q;
          gnt_d[owner_q] = 1'b1;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end

      OWN: begin
        if (owner_dir_q) begin
          out_d = wbyte[owner_q];
        end else begin
          rdata_d  = uio_in;
          rvalid_d = 1'b1;
        end

        if (!ena) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (!req[owner_q] || (hold_q == HOLD_LAST)) begin
          state_d  = IDLE;
          hold_d   = '0;
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
        end else begin
          hold_d         = hold_q + 8'd1;
          gnt_d[owner_q] = 1'b1;
          oe_d           = owner_dir_q ? 8'hFF : 8'h00;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and registered outputs, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      owner_dir_q <= 1'b0;
      rr_ptr_q    <= '0;
      last_dir_q  <= 1'b0;
      hold_q      <= '0;
      turn_q      <= '0;
      gnt         <= '0;
      uio_oe      <= 8'h00;
      uio_out     <= 8'h00;
      rdata       <= 8'h00;
      rvalid      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      owner_dir_q <= owner_dir_d;
      rr_ptr_q    <= rr_ptr_d;
      last_dir_q  <= last_dir_d;
      hold_q      <= hold_d;
      turn_q      <= turn_d;
      gnt         <= gnt_d;
      uio_oe      <= oe_d;
      uio_out     <= out_d;
      rdata       <= rdata_d;
      rvalid      <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// model of the bus ownership predicts the outputs for every cycle.
module tb_uio_bus_arbiter;

  localparam int N_REQ    = 4;
  localparam int TURN_CYC = 1;
  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  dir;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Model state: the owner index (-1 means the bus is free), the dead cycles
  // still to wait, the OWN cycles used so far, the round-robin start point
  // and the direction the bus last settled in.
  int m_owner;
  int m_turn;
  int m_held;
  int m_ptr;
  int m_last_dir;
  int m_dir;

  logic [3:0] e_gnt;
  logic [7:0] e_oe;
  logic [7:0] e_out;
  logic [7:0] e_rdata;
  logic       e_rvalid;

  logic [3:0] grant_seq [$];
  int         run_lens  [$];
  int         run_len;
  logic [3:0] exp_seq   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  uio_bus_arbiter #(
    .N_REQ    (N_REQ),
    .TURN_CYC (TURN_CYC),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .dir     (dir),
    .wdata   (wdata),
    .gnt     (gnt),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Free-running clock.
  initial begin
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input logic e);
    req = r;
    dir = d;
    ena = e;
  endtask

  task automatic modelReset();
    m_owner    = -1;
    m_turn     = 0;
    m_held     = 0;
    m_ptr      = 0;
    m_last_dir = 0;
    m_dir      = 0;
    e_gnt      = '0;
    e_oe       = '0;
    e_out      = '0;
    e_rdata    = '0;
    e_rvalid   = 1'b0;
  endtask

  function automatic bit reqBit(input int i);
    return ((req >> i) & 4'd1) != 4'd0;
  endfunction

  // Advance the model by one clock, using the inputs present before the edge.
  task automatic modelStep();
    if (!rst_n) begin
      modelReset();
      return;
    end
    e_gnt    = '0;
    e_oe     = '0;
    e_rvalid = 1'b0;
    if (m_owner < 0) begin
      if (ena && req != 4'd0) begin
        for (int k = 0; k < N_REQ; k++) begin
          int c;
          c = (m_ptr + k) % N_REQ;
          if (m_owner < 0 && reqBit(c)) m_owner = c;
        end
        m_dir  = int'((dir >> m_owner) & 4'd1);
        m_held = 0;
        if (m_dir == m_last_dir) begin
          m_turn = 0;
          e_gnt  = 4'(1 << m_owner);
        end else begin
          m_turn = TURN_CYC;
        end
      end
    end else if (m_turn > 0) begin
      if (!ena) begin
        m_owner = -1;
        m_turn  = 0;
      end else begin
        m_turn--;
        if (m_turn == 0) begin
          m_last_dir = m_dir;
          e_gnt      = 4'(1 << m_owner);
        end
      end
    end else begin
      if (m_dir == 1) begin
        e_out = 8'(wdata >> (8 * m_owner));
      end else begin
        e_rdata  = uio_in;
        e_rvalid = 1'b1;
      end
      m_held++;
      if (!ena) begin
        m_owner = -1;
      end else if (!reqBit(m_owner) || m_held == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % N_REQ;
        m_owner = -1;
      end else begin
        e_gnt = 4'(1 << m_owner);
        e_oe  = (m_dir == 1) ? 8'hFF : 8'h00;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".gnt"},     32'(gnt),             32'(e_gnt));
    checkOutput({tag, ".oe"},      32'(uio_oe),          32'(e_oe));
    checkOutput({tag, ".out"},     32'(uio_out),         32'(e_out));
    checkOutput({tag, ".rdata"},   32'(rdata),           32'(e_rdata));
    checkOutput({tag, ".rvalid"},  32'(rvalid),          32'(e_rvalid));
    checkOutput({tag, ".onehot"},  32'($onehot0(gnt)),   32'(1));
  endtask

  task automatic stepCycle(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    checkModel(tag);
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    req    = '0;
    dir    = '0;
    wdata  = '0;
    uio_in = '0;
    modelReset();
    #1;
    checkModel("reset");
    stepCycle("reset_hold");
    stepCycle("reset_hold");
    rst_n = 1'b1;

    // Single writer from reset: one turnaround cycle, then the write.
    $display("[TB] single writer with turnaround");
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    wdata = 32'h0000_00A5;
    stepCycle("wr_turn");
    checkOutput("wr_turn_gnt", 32'(gnt), 32'h0);
    stepCycle("wr_gnt");
    checkOutput("wr_gnt_t2", 32'(gnt), 32'h1);
    checkOutput("wr_oe_t2", 32'(uio_oe), 32'h00);
    stepCycle("wr_data");
    checkOutput("wr_oe_t3", 32'(uio_oe), 32'hFF);
    checkOutput("wr_out_t3", 32'(uio_out), 32'hA5);

    // Asynchronous reset in the middle of a write grant.
    $display("[TB] async reset mid write");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_gnt", 32'(gnt), 32'h0);
    checkOutput("arst_oe", 32'(uio_oe), 32'h00);
    checkOutput("arst_out", 32'(uio_out), 32'h00);
    modelReset();
    stepCycle("arst_hold");
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    stepCycle("arst_idle");
    checkOutput("arst_idle_gnt", 32'(gnt), 32'h0);

    // All four readers requesting: full-length grants in rotation.
    $display("[TB] round robin with full hold");
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    run_len = 0;
    for (int i = 0; i < 45; i++) begin
      stepCycle("rr");
      if (gnt != 4'd0) begin
        if (run_len == 0) grant_seq.push_back(gnt);
        run_len++;
      end else if (run_len != 0) begin
        run_lens.push_back(run_len);
        run_len = 0;
      end
    end
    checkOutput("rr_grants", 32'(grant_seq.size()), 32'd5);
    checkOutput("rr_runs", 32'(run_lens.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_seq%0d", i), 32'(grant_seq[i]), 32'(exp_seq[i]));
      checkOutput($sformatf("rr_len%0d", i), 32'(run_lens[i]), 32'd8);
    end

    // Writer 1 for two cycles, then reader 2 after a turnaround.
    $display("[TB] write then read");
    applyStimulus(4'b0010, 4'b0010, 1'b1);
    wdata = 32'h0000_5A00;
    stepCycle("wr1_turn");
    stepCycle("wr1_own");
    checkOutput("wr1_gnt", 32'(gnt), 32'h2);
    stepCycle("wr1_own2");
    checkOutput("wr1_oe_ff", 32'(uio_oe), 32'hFF);
    checkOutput("wr1_out", 32'(uio_out), 32'h5A);
    applyStimulus(4'b0100, 4'b0010, 1'b1);
    uio_in = 8'h3C;
    stepCycle("wr1_release");
    checkOutput("wr1_oe_00", 32'(uio_oe), 32'h00);
    stepCycle("rd2_turn");
    checkOutput("rd2_turn_gnt", 32'(gnt), 32'h0);
    stepCycle("rd2_own");
    checkOutput("rd2_gnt", 32'(gnt), 32'h4);
    stepCycle("rd2_data");
    checkOutput("rd2_rdata", 32'(rdata), 32'h3C);
    checkOutput("rd2_rvalid", 32'(rvalid), 32'h1);

    // Disabling the tile mid-grant leaves the round-robin pointer alone.
    $display("[TB] ena drop mid grant");
    applyStimulus(4'b0100, 4'b0010, 1'b0);
    stepCycle("ena_off");
    checkOutput("ena_off_gnt", 32'(gnt), 32'h0);
    checkOutput("ena_off_oe", 32'(uio_oe), 32'h00);
    applyStimulus(4'b0101, 4'b0000, 1'b1);
    stepCycle("ena_on");
    checkOutput("ena_regrant", 32'(gnt), 32'h4);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    stepCycle("ptr_rel2");
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    stepCycle("ptr_own0");
    checkOutput("ptr_gnt0", 32'(gnt), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    stepCycle("ptr_rel0");

    // rr_ptr is 1 here: requester 2 wins, then requester 0 after a turn.
    $display("[TB] drop request during turnaround");
    applyStimulus(4'b0101, 4'b0001, 1'b1);
    stepCycle("t6_own2");
    checkOutput("t6_gnt2", 32'(gnt), 32'h4);
    stepCycle("t6_hold2");
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    stepCycle("t6_rel2");
    checkOutput("t6_rel2_gnt", 32'(gnt), 32'h0);
    stepCycle("t6_turn0");
    checkOutput("t6_turn_gnt", 32'(gnt), 32'h0);
    applyStimulus(4'b0000, 4'b0001, 1'b1);
    stepCycle("t6_own0");
    checkOutput("t6_gnt0", 32'(gnt), 32'h1);
    stepCycle("t6_rel0");
    checkOutput("t6_rel0_gnt", 32'(gnt), 32'h0);
    checkOutput("t6_rel0_oe", 32'(uio_oe), 32'h00);

    // Randomized traffic with one asynchronous reset pulse midway.
    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      if ($urandom_range(7) == 0) dir = 4'($urandom);
      ena    = ($urandom_range(15) != 0);
      wdata  = $urandom;
      uio_in = 8'($urandom);
      if (i == 250) begin
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkModel("rnd_arst");
        #1;
        rst_n = 1'b1;
      end
      stepCycle("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
